// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the conv weight scheduler slice.
package conv_pkg;

  localparam int BIT_DEPTH  = 16;
  localparam int N_PER_PORT = 14;
  localparam int ADDR_W     = 5;
  localparam int RD_LAT     = 2;
  localparam int CONV_LAT   = 3;

  localparam int BEAT_W   = 5;
  localparam int RD_CNT_W = 4;

  localparam logic [ADDR_W-1:0] IDLE_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_FLUSH,
    S_READY
  } state_e;

endpackage

// File: rtl/conv_weight_sched_if.sv
// Weight stream handshake plus dual-port weight BRAM bus.
interface conv_weight_sched_if #(
  parameter int BIT_DEPTH = conv_pkg::BIT_DEPTH,
  parameter int ADDR_W    = conv_pkg::ADDR_W
) ();

  logic [BIT_DEPTH-1:0] wt_data;
  logic                 wt_valid;
  logic                 wt_ready;

  logic                 bram_wren_a;
  logic                 bram_wren_b;
  logic [ADDR_W-1:0]    bram_addr_a;
  logic [ADDR_W-1:0]    bram_addr_b;
  logic [BIT_DEPTH-1:0] bram_data_a;
  logic [BIT_DEPTH-1:0] bram_data_b;

  modport master (
    input  wt_data, wt_valid,
    output wt_ready,
    output bram_wren_a, bram_wren_b, bram_addr_a, bram_addr_b,
    output bram_data_a, bram_data_b
  );

  modport slave (
    output wt_data, wt_valid,
    input  wt_ready,
    input  bram_wren_a, bram_wren_b, bram_addr_a, bram_addr_b,
    input  bram_data_a, bram_data_b
  );

endinterface

// File: rtl/conv_weight_sched_valid_delay.sv
// N-deep single-bit valid pipe; dout is din delayed by exactly N cycles.
module valid_delay #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic RESET_n,
  input  logic din,
  output logic dout
);

  logic [N-1:0] pipe;

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int unsigned i = 1; i < N; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign dout = pipe[N-1];

endmodule

// File: rtl/conv_weight_sched.sv
// Loads 28 weight words into the dual-port weight BRAM, replays them into the
// weight shift registers, then gates conv windows and tracks their results.
module conv_weight_sched #(
  parameter int BIT_DEPTH  = conv_pkg::BIT_DEPTH,
  parameter int N_PER_PORT = conv_pkg::N_PER_PORT,
  parameter int ADDR_W     = conv_pkg::ADDR_W,
  parameter int RD_LAT     = conv_pkg::RD_LAT,
  parameter int CONV_LAT   = conv_pkg::CONV_LAT
) (
  input  logic                clk,
  input  logic                RESET_n,
  input  logic                cfg_start,
  conv_weight_sched_if.master wt_bus,
  output logic                shift_en,
  output logic                weights_ready,
  output logic                busy,
  input  logic                win_valid,
  output logic                win_ready,
  output logic                res_valid
);

  import conv_pkg::*;

  localparam int LAST_BEAT = 2 * N_PER_PORT - 1;
  localparam int LAST_RD   = N_PER_PORT - 1;

  state_e              state, state_nxt;
  logic [BEAT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic [RD_CNT_W-1:0] rd_cnt, rd_cnt_nxt;
  logic                beat_fire;

  logic                 wt_ready_d, wren_a_d, wren_b_d, rd_issue_d, rd_issue;
  logic [ADDR_W-1:0]    addr_a_d, addr_b_d;
  logic [BIT_DEPTH-1:0] data_a_d, data_b_d;
  logic                 busy_d, weights_ready_d;

  // wt_ready is high throughout WRITE, so a valid beat there is always accepted.
  assign beat_fire = (state == S_WRITE) && wt_bus.wt_valid;

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      rd_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      rd_cnt   <= rd_cnt_nxt;
    end
  end

  // rd_cnt is reused in FLUSH to count out the RD_LAT drain cycles.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    rd_cnt_nxt   = rd_cnt;
    unique case (state)
      S_IDLE, S_READY: begin
        if (cfg_start) begin
          state_nxt    = S_WRITE;
          beat_cnt_nxt = '0;
        end
      end
      S_WRITE: begin
        if (beat_fire) begin
          if (beat_cnt == BEAT_W'(LAST_BEAT)) begin
            state_nxt  = S_READ;
            rd_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      S_READ: begin
        if (rd_cnt == RD_CNT_W'(LAST_RD)) begin
          state_nxt  = S_FLUSH;
          rd_cnt_nxt = '0;
        end else begin
          rd_cnt_nxt = rd_cnt + 1'b1;
        end
      end
      S_FLUSH: begin
        if (rd_cnt == RD_CNT_W'(RD_LAT)) begin
          state_nxt  = S_READY;
          rd_cnt_nxt = '0;
        end else begin
          rd_cnt_nxt = rd_cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wt_ready_d      = (state_nxt == S_WRITE);
    busy_d          = (state_nxt == S_WRITE) || (state_nxt == S_READ) ||
                      (state_nxt == S_FLUSH);
    weights_ready_d = (state_nxt == S_READY);
    rd_issue_d      = (state == S_READ);
    wren_a_d        = beat_fire && (beat_cnt < BEAT_W'(N_PER_PORT));
    wren_b_d        = beat_fire && (beat_cnt >= BEAT_W'(N_PER_PORT));
    addr_a_d        = IDLE_ADDR;
    addr_b_d        = IDLE_ADDR;
    data_a_d        = '0;
    data_b_d        = '0;
    if (wren_a_d) begin
      addr_a_d = ADDR_W'(beat_cnt);
      data_a_d = wt_bus.wt_data;
    end
    if (wren_b_d) begin
      addr_b_d = ADDR_W'(beat_cnt);
      data_b_d = wt_bus.wt_data;
    end
    if (state == S_READ) begin
      addr_a_d = ADDR_W'(rd_cnt);
      addr_b_d = ADDR_W'(N_PER_PORT) + ADDR_W'(rd_cnt);
    end
  end

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      wt_bus.wt_ready    <= 1'b0;
      wt_bus.bram_wren_a <= 1'b0;
      wt_bus.bram_wren_b <= 1'b0;
      wt_bus.bram_addr_a <= IDLE_ADDR;
      wt_bus.bram_addr_b <= IDLE_ADDR;
      wt_bus.bram_data_a <= '0;
      wt_bus.bram_data_b <= '0;
      rd_issue           <= 1'b0;
      busy               <= 1'b0;
      weights_ready      <= 1'b0;
    end else begin
      wt_bus.wt_ready    <= wt_ready_d;
      wt_bus.bram_wren_a <= wren_a_d;
      wt_bus.bram_wren_b <= wren_b_d;
      wt_bus.bram_addr_a <= addr_a_d;
      wt_bus.bram_addr_b <= addr_b_d;
      wt_bus.bram_data_a <= data_a_d;
      wt_bus.bram_data_b <= data_b_d;
      rd_issue           <= rd_issue_d;
      busy               <= busy_d;
      weights_ready      <= weights_ready_d;
    end
  end

  assign win_ready = weights_ready;

  valid_delay #(.N(RD_LAT)) u_shift_dly (
    .clk     (clk),
    .RESET_n (RESET_n),
    .din     (rd_issue),
    .dout    (shift_en)
  );

  valid_delay #(.N(CONV_LAT)) u_res_dly (
    .clk     (clk),
    .RESET_n (RESET_n),
    .din     (win_valid && weights_ready),
    .dout    (res_valid)
  );

endmodule

// File: tb/tb_conv_weight_sched.sv
// Randomized bench for conv_weight_sched against a timeline-based reference model.
module tb_conv_weight_sched;

  import conv_pkg::*;

  localparam int BD   = 16;
  localparam int AW   = 5;
  localparam int NP   = 14;
  localparam int RDL  = 2;
  localparam int CL   = 3;
  localparam int RING = 64;

  logic clk = 1'b0;
  logic RESET_n;
  logic cfg_start;
  logic win_valid;
  logic shift_en, weights_ready, busy, win_ready, res_valid;

  conv_weight_sched_if #(.BIT_DEPTH(BD), .ADDR_W(AW)) bus ();

  conv_weight_sched #(
    .BIT_DEPTH  (BD),
    .N_PER_PORT (NP),
    .ADDR_W     (AW),
    .RD_LAT     (RDL),
    .CONV_LAT   (CL)
  ) dut (
    .clk           (clk),
    .RESET_n       (RESET_n),
    .cfg_start     (cfg_start),
    .wt_bus        (bus),
    .shift_en      (shift_en),
    .weights_ready (weights_ready),
    .busy          (busy),
    .win_valid     (win_valid),
    .win_ready     (win_ready),
    .res_valid     (res_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: level flags for the current cycle plus a ring of scheduled events.
  bit m_wt_ready, m_busy, m_wrdy;
  bit n_wt_ready, n_busy, n_wrdy;
  int m_beats;
  int m_last_w;
  int shift_seen;

  bit r_wren_a[RING], r_wren_b[RING], r_shift[RING], r_res[RING], r_evt[RING];
  int r_addr_a[RING], r_addr_b[RING], r_data_a[RING], r_data_b[RING];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clr_slot(input int s);
    r_wren_a[s] = 1'b0;
    r_wren_b[s] = 1'b0;
    r_addr_a[s] = int'(IDLE_ADDR);
    r_addr_b[s] = int'(IDLE_ADDR);
    r_data_a[s] = 0;
    r_data_b[s] = 0;
    r_shift[s]  = 1'b0;
    r_res[s]    = 1'b0;
    r_evt[s]    = 1'b0;
  endtask

  task automatic model_clear();
    for (int s = 0; s < RING; s++) clr_slot(s);
    m_wt_ready = 1'b0; m_busy = 1'b0; m_wrdy = 1'b0;
    n_wt_ready = 1'b0; n_busy = 1'b0; n_wrdy = 1'b0;
    m_beats    = 0;
    m_last_w   = -1;
    shift_seen = 0;
  endtask

  task automatic check_reset();
    chk("rst_wt_ready", bus.wt_ready, 0);
    chk("rst_wren_a", bus.bram_wren_a, 0);
    chk("rst_wren_b", bus.bram_wren_b, 0);
    chk("rst_addr_a", bus.bram_addr_a, 31);
    chk("rst_addr_b", bus.bram_addr_b, 31);
    chk("rst_data_a", bus.bram_data_a, 0);
    chk("rst_data_b", bus.bram_data_b, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_weights_ready", weights_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_win_ready", win_ready, 0);
    chk("rst_res_valid", res_valid, 0);
  endtask

  task automatic compare();
    int s;
    s = cyc % RING;
    chk("wt_ready", bus.wt_ready, m_wt_ready);
    chk("wren_a", bus.bram_wren_a, r_wren_a[s]);
    chk("wren_b", bus.bram_wren_b, r_wren_b[s]);
    chk("addr_a", bus.bram_addr_a, r_addr_a[s]);
    chk("addr_b", bus.bram_addr_b, r_addr_b[s]);
    if (r_wren_a[s]) chk("data_a", bus.bram_data_a, r_data_a[s]);
    if (r_wren_b[s]) chk("data_b", bus.bram_data_b, r_data_b[s]);
    chk("shift_en", shift_en, r_shift[s]);
    chk("weights_ready", weights_ready, m_wrdy);
    chk("win_ready", win_ready, m_wrdy);
    chk("busy", busy, m_busy);
    chk("res_valid", res_valid, r_res[s]);
    if (shift_en === 1'b1) shift_seen++;
    clr_slot(s);
  endtask

  // Schedules everything the inputs of cycle cyc imply, straight from the timing rules.
  task automatic model_update(input bit cfg, input bit wv, input logic [BD-1:0] wd, input bit winv);
    int c;
    c = cyc;
    n_wt_ready = m_wt_ready;
    n_busy     = m_busy;
    n_wrdy     = m_wrdy;
    if (cfg && !m_busy) begin
      n_wt_ready = 1'b1;
      n_busy     = 1'b1;
      n_wrdy     = 1'b0;
      m_beats    = 0;
      m_last_w   = -1;
    end
    if (m_wt_ready && wv) begin
      if (m_beats < NP) begin
        r_wren_a[(c+1)%RING] = 1'b1;
        r_addr_a[(c+1)%RING] = m_beats;
        r_data_a[(c+1)%RING] = int'(wd);
      end else begin
        r_wren_b[(c+1)%RING] = 1'b1;
        r_addr_b[(c+1)%RING] = m_beats;
        r_data_b[(c+1)%RING] = int'(wd);
      end
      m_beats++;
      if (m_beats == 2*NP) begin
        n_wt_ready = 1'b0;
        m_last_w   = c;
        for (int i = 0; i < NP; i++) begin
          r_addr_a[(c+2+i)%RING]     = i;
          r_addr_b[(c+2+i)%RING]     = NP + i;
          r_shift[(c+2+RDL+i)%RING]  = 1'b1;
        end
        r_evt[(c+16+RDL)%RING] = 1'b1;
      end
    end
    if (m_wrdy && winv) r_res[(c+CL)%RING] = 1'b1;
  endtask

  task automatic advance();
    int s;
    cyc++;
    s = cyc % RING;
    m_wt_ready = n_wt_ready;
    m_busy     = n_busy;
    m_wrdy     = n_wrdy;
    if (r_evt[s]) begin
      r_evt[s] = 1'b0;
      m_busy   = 1'b0;
      m_wrdy   = 1'b1;
      chk("shift_count", shift_seen, NP);
      shift_seen = 0;
    end
  endtask

  task automatic step(input bit cfg, input bit wv, input logic [BD-1:0] wd, input bit winv);
    compare();
    cfg_start    = cfg;
    bus.wt_valid = wv;
    bus.wt_data  = wd;
    win_valid    = winv;
    model_update(cfg, wv, wd, winv);
    @(posedge clk);
    @(negedge clk);
    advance();
  endtask

  task automatic async_reset();
    #2;
    RESET_n      = 1'b0;
    cfg_start    = 1'b0;
    bus.wt_valid = 1'b0;
    bus.wt_data  = '0;
    win_valid    = 1'b0;
    #1;
    check_reset();
    model_clear();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    RESET_n = 1'b1;
  endtask

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // mode 0: contiguous, data 1..28; mode 1: valid every other cycle; mode 2: random valid.
  task automatic run_load(input int mode, input bit poke, input bit rst7);
    int n;
    bit wv, cfg;
    logic [BD-1:0] wd;
    step(1'b1, 1'b0, '0, rbit());
    n = 0;
    while (!m_wrdy && n < 300) begin
      if (rst7 && m_last_w >= 0 && cyc == m_last_w + 9) begin
        compare();
        async_reset();
        return;
      end
      case (mode)
        0:       wv = 1'b1;
        1:       wv = (n % 2 == 0);
        default: wv = rbit();
      endcase
      wd  = (mode == 0) ? BD'(m_beats + 1) : BD'($urandom);
      cfg = poke && ((m_wt_ready && m_beats == 5) ||
                     (m_last_w >= 0 && cyc == m_last_w + 6));
      step(cfg, wv, wd, rbit());
      n++;
    end
    chk("load_done", m_wrdy, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET_n      = 1'b1;
    cfg_start    = 1'b0;
    win_valid    = 1'b0;
    bus.wt_valid = 1'b0;
    bus.wt_data  = '0;
    model_clear();
    #1 RESET_n = 1'b0;
    #1 check_reset();
    @(negedge clk);
    @(negedge clk);
    RESET_n = 1'b1;

    for (int i = 0; i < 6; i++) step(1'b0, rbit(), BD'($urandom), rbit());

    run_load(0, 1'b0, 1'b0);

    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, rbit());

    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    run_load(1, 1'b1, 1'b0);
    run_load(2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, rbit());

    run_load(2, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, rbit(), BD'($urandom), rbit());

    run_load(2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, rbit());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_weight_sched.md
# conv_weight_sched

Controller that sequences the weight BRAM feeding the three-channel conv datapath. It accepts a stream of 28 weight words and writes them into the 32-entry dual-port weight BRAM, 14 words on each port. It then reads them back in lockstep on both ports, driving shift-enable into the 14-deep weight shift registers. Once the weights are resident, it gates input windows into the conv/adder datapath and tracks their results out.

## Interface
Parameters:
- BIT_DEPTH, 16, weight word width
- N_PER_PORT, 14, words per BRAM port (27 used weights + 1 pad)
- ADDR_W, 5, BRAM address width; idle address is all-ones (31)
- RD_LAT, 2, BRAM read latency, address to q_a/q_b valid at the shift registers
- CONV_LAT, 3, window-in to result-out latency of the conv + paral_add datapath

Ports:
- clk  in  1  single clock; all logic on posedge
- RESET_n  in  1  asynchronous, active-low reset
- cfg_start  in  1  one-cycle pulse: begin a weight load
- wt_data  in  BIT_DEPTH  weight stream word
- wt_valid  in  1  wt_data valid
- wt_ready  out  1  controller accepts wt_data
- bram_wren_a, bram_wren_b  out  1  BRAM write enables
- bram_addr_a, bram_addr_b  out  ADDR_W  BRAM addresses
- bram_data_a, bram_data_b  out  BIT_DEPTH  BRAM write data
- shift_en  out  1  advance both weight shift registers (w1 from q_a, w2 from q_b)
- weights_ready  out  1  weight registers hold a complete, current set
- busy  out  1  load in progress (WRITE or READ/FLUSH)
- win_valid  in  1  a 9-pixel window is presented to the datapath
- win_ready  out  1  equals weights_ready
- res_valid  out  1  datapath result output is valid this cycle

## Operation
- States: IDLE, WRITE, READ, FLUSH, READY.
- IDLE: all outputs at reset values. cfg_start moves to WRITE.
- WRITE: wt_ready=1.
  - Beat k (0..13) writes port A: bram_wren_a=1, bram_addr_a=k, bram_data_a=wt_data.
  - Beat k (14..27) writes port B: bram_wren_b=1, bram_addr_b=k, bram_data_b=wt_data.
  - The inactive port holds address 31 with wren 0.
  - A cycle with wt_valid=0 produces no write and does not advance the count.
  - After beat 27: go to READ, wt_ready=0.
- READ: for i=0..13, issue bram_addr_a=i and bram_addr_b=14+i in the same cycle; both wren=0. After i=13, go to FLUSH.
- FLUSH: addresses 31. Wait until all RD_LAT-delayed shift_en pulses have drained, then go to READY.
- shift_en is the read-issue strobe delayed by RD_LAT through a shift register, giving exactly 14 pulses per load.
- READY: weights_ready=1, win_ready=1.
  - Each cycle with win_valid && win_ready enters a CONV_LAT-deep valid pipe; res_valid is its output.
  - cfg_start moves to WRITE and drops weights_ready the next cycle.
  - Windows already in the valid pipe still emerge on res_valid.
- cfg_start is ignored in WRITE, READ and FLUSH.
- win_valid is ignored unless weights_ready=1.
- Reset (async, any state) returns to IDLE and clears all counters and pipes. A partial load is discarded; weights_ready stays 0 until a full reload.

## Timing
- Reset values:
  - wt_ready, bram_wren_a/b, shift_en, weights_ready, busy, res_valid, win_ready: 0
  - bram_addr_a/b: 31
  - bram_data_a/b: 0
- All outputs are registered.
- cfg_start sampled at cycle t: WRITE and wt_ready=1 at t+1; busy=1 from t+1.
- Write latency: a beat accepted at cycle c appears on bram_* at c+1.
- Last beat accepted at w: read addresses i=0..13 at cycles w+2..w+15.
- shift_en pulses at w+2+RD_LAT .. w+15+RD_LAT.
- weights_ready=1 and busy=0 at w+16+RD_LAT.
- Minimum load: 28 beats + 15 + RD_LAT cycles.
- res_valid is asserted exactly CONV_LAT cycles after each accepted window. Gaps are preserved and there is no reordering.

## Structure
- Shared package (conv_pkg): BIT_DEPTH, ADDR_W, N_PER_PORT, IDLE_ADDR=31, and the state encoding.
- One sub-module: valid_delay (parameterised depth N, 1-bit shift pipe with async active-low clear).
  - Instance 1 with N=RD_LAT generates shift_en.
  - Instance 2 with N=CONV_LAT generates res_valid.
- FSM, beat counter (5 bits) and read counter (4 bits) stay in the top module.

## Test plan
- Full load, wt_valid held high, words 1..28: port A writes addr 0..13 with data 1..14, then port B writes addr 14..27 with data 15..28. Read pairs (0,14)..(13,27) follow. shift_en pulses exactly 14 times. weights_ready rises at w+18 with RD_LAT=2.
- Stream with wt_valid low every other cycle: write count is still 28 and addresses stay contiguous. Load takes 56 beat cycles; final timing is relative to the last beat.
- cfg_start pulsed during WRITE and again during READ: both are ignored, with no address restart. In READY, cfg_start drops weights_ready at t+1 and restarts the write at address 0.
- Windows on cycles r, r+1 and r+3 in READY with CONV_LAT=3: res_valid is high at r+3, r+4 and r+6, and low otherwise. A win_valid asserted before READY yields no res_valid.
- RESET_n asserted mid-READ at beat i=7: all outputs return to reset values immediately. After release, the controller stays in IDLE with weights_ready=0 until cfg_start.
- Back-to-back reloads: the second load is issued at the cycle weights_ready rises. Exactly 14 shift_en pulses occur per load, and res_valid from pre-reload windows still appears.
